// File: rtl/bp_uce_stream_merge.sv
// +--------------------------------------------------------------------------+
// | bp_uce_stream_merge: merges the I$/D$ UCE command streams onto one port  |
// | and routes in-order responses back through a source-tracking FIFO.       |
// | Optional: BP_UCE_STREAM_MERGE_FIXED_PRIO_EN makes D$ always win a tie.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package bp_uce_stream_merge_pkg;
  typedef enum logic [1:0] {
    e_bp_default_cfg   = 2'd0,
    e_bp_half_fill_cfg = 2'd1
  } bp_params_e;

  function automatic int mem_header_width(bp_params_e cfg);
    return (cfg == e_bp_half_fill_cfg) ? 48 : 64;
  endfunction

  function automatic int uce_fill_width(bp_params_e cfg);
    return (cfg == e_bp_half_fill_cfg) ? 32 : 64;
  endfunction
endpackage

module bp_uce_stream_merge
  import bp_uce_stream_merge_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int outstanding_p = 4,
  localparam int mem_header_width_lp = mem_header_width(bp_params_p),
  localparam int uce_fill_width_p = uce_fill_width(bp_params_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,

  input  logic [1:0][mem_header_width_lp-1:0] mem_cmd_header_i,
  input  logic [1:0][uce_fill_width_p-1:0]    mem_cmd_data_i,
  input  logic [1:0]                          mem_cmd_v_i,
  input  logic [1:0]                          mem_cmd_last_i,
  output logic [1:0]                          mem_cmd_ready_and_o,

  output logic [mem_header_width_lp-1:0]      mem_cmd_header_o,
  output logic [uce_fill_width_p-1:0]         mem_cmd_data_o,
  output logic                                mem_cmd_v_o,
  output logic                                mem_cmd_last_o,
  input  logic                                mem_cmd_ready_and_i,

  input  logic [mem_header_width_lp-1:0]      mem_resp_header_i,
  input  logic [uce_fill_width_p-1:0]         mem_resp_data_i,
  input  logic                                mem_resp_v_i,
  input  logic                                mem_resp_last_i,
  output logic                                mem_resp_ready_and_o,

  output logic [1:0][mem_header_width_lp-1:0] mem_resp_header_o,
  output logic [1:0][uce_fill_width_p-1:0]    mem_resp_data_o,
  output logic [1:0]                          mem_resp_v_o,
  output logic [1:0]                          mem_resp_last_o,
  input  logic [1:0]                          mem_resp_ready_and_i
);

  localparam int ptr_w_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(outstanding_p + 1);
  localparam logic [cnt_w_lp-1:0] c_depth   = cnt_w_lp'(outstanding_p);
  localparam logic [ptr_w_lp-1:0] c_ptr_max = ptr_w_lp'(outstanding_p - 1);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_lock = 1'b1
  } state_e;

  state_e                   r_state;
  logic                     r_lock_port;
  logic [outstanding_p-1:0] r_src;
  logic [ptr_w_lp-1:0]      r_wptr;
  logic [ptr_w_lp-1:0]      r_rptr;
  logic [cnt_w_lp-1:0]      r_count;

  logic w_full, w_empty, w_idle_grant, w_grant, w_active;
  logic w_cmd_hs, w_push, w_pop, w_head;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

`ifdef BP_UCE_STREAM_MERGE_FIXED_PRIO_EN
  // D$ wins whenever it requests; I$ only gets the bus when D$ is quiet
  assign w_idle_grant = mem_cmd_v_i[1];
`else
  logic rr_r;
  assign w_idle_grant = (&mem_cmd_v_i) ? rr_r : mem_cmd_v_i[1];
`endif

  assign w_grant  = (r_state == e_lock) ? r_lock_port : w_idle_grant;
  // A locked message must finish even with a full FIFO: its entry is already in
  assign w_active = ~reset_i & ((r_state == e_lock) | ~w_full);

  assign mem_cmd_header_o = mem_cmd_header_i[w_grant];
  assign mem_cmd_data_o   = mem_cmd_data_i[w_grant];
  assign mem_cmd_last_o   = mem_cmd_last_i[w_grant];
  assign mem_cmd_v_o      = w_active & mem_cmd_v_i[w_grant];

  always_comb begin
    mem_cmd_ready_and_o          = '0;
    mem_cmd_ready_and_o[w_grant] = w_active & mem_cmd_ready_and_i;
  end

  assign w_cmd_hs = mem_cmd_v_o & mem_cmd_ready_and_i;
  assign w_push   = w_cmd_hs & (r_state == e_idle);

  assign w_head               = r_src[r_rptr];
  assign mem_resp_header_o    = {2{mem_resp_header_i}};
  assign mem_resp_data_o      = {2{mem_resp_data_i}};
  assign mem_resp_last_o      = {2{mem_resp_last_i}};
  assign mem_resp_ready_and_o = ~reset_i & ~w_empty & mem_resp_ready_and_i[w_head];

  always_comb begin
    mem_resp_v_o         = '0;
    mem_resp_v_o[w_head] = ~reset_i & ~w_empty & mem_resp_v_i;
  end

  assign w_pop = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_idle;
      r_lock_port <= 1'b0;
      r_src       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
`ifndef BP_UCE_STREAM_MERGE_FIXED_PRIO_EN
      rr_r        <= 1'b0;
`endif
    end else begin
      if (w_cmd_hs) begin
        if ((r_state == e_idle) && !mem_cmd_last_o) begin
          r_state     <= e_lock;
          r_lock_port <= w_grant;
        end else if ((r_state == e_lock) && mem_cmd_last_o) begin
          r_state <= e_idle;
        end
`ifndef BP_UCE_STREAM_MERGE_FIXED_PRIO_EN
        if (mem_cmd_last_o) begin
          rr_r <= ~w_grant;
        end
`endif
      end
      if (w_push) begin
        r_src[r_wptr] <= w_grant;
        r_wptr        <= (r_wptr == c_ptr_max) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_ptr_max) ? '0 : r_rptr + 1'b1;
      end
      r_count <= r_count + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_uce_stream_merge.sv
// +--------------------------------------------------------------------------+
// | tb_bp_uce_stream_merge: randomized bench against a queue-based model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bp_uce_stream_merge;
  import bp_uce_stream_merge_pkg::*;

  localparam int HW   = mem_header_width(e_bp_default_cfg);
  localparam int FW   = uce_fill_width(e_bp_default_cfg);
  localparam int OUTS = 4;
`ifdef BP_UCE_STREAM_MERGE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;
  logic [1:0][HW-1:0]   mem_cmd_header_i;
  logic [1:0][FW-1:0]   mem_cmd_data_i;
  logic [1:0]           mem_cmd_v_i, mem_cmd_last_i, mem_cmd_ready_and_o;
  logic [HW-1:0]        mem_cmd_header_o;
  logic [FW-1:0]        mem_cmd_data_o;
  logic                 mem_cmd_v_o, mem_cmd_last_o, mem_cmd_ready_and_i;
  logic [HW-1:0]        mem_resp_header_i;
  logic [FW-1:0]        mem_resp_data_i;
  logic                 mem_resp_v_i, mem_resp_last_i, mem_resp_ready_and_o;
  logic [1:0][HW-1:0]   mem_resp_header_o;
  logic [1:0][FW-1:0]   mem_resp_data_o;
  logic [1:0]           mem_resp_v_o, mem_resp_last_o, mem_resp_ready_and_i;

  bp_uce_stream_merge #(.bp_params_p(e_bp_default_cfg), .outstanding_p(OUTS)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .mem_cmd_header_i    (mem_cmd_header_i),
    .mem_cmd_data_i      (mem_cmd_data_i),
    .mem_cmd_v_i         (mem_cmd_v_i),
    .mem_cmd_last_i      (mem_cmd_last_i),
    .mem_cmd_ready_and_o (mem_cmd_ready_and_o),
    .mem_cmd_header_o    (mem_cmd_header_o),
    .mem_cmd_data_o      (mem_cmd_data_o),
    .mem_cmd_v_o         (mem_cmd_v_o),
    .mem_cmd_last_o      (mem_cmd_last_o),
    .mem_cmd_ready_and_i (mem_cmd_ready_and_i),
    .mem_resp_header_i   (mem_resp_header_i),
    .mem_resp_data_i     (mem_resp_data_i),
    .mem_resp_v_i        (mem_resp_v_i),
    .mem_resp_last_i     (mem_resp_last_i),
    .mem_resp_ready_and_o(mem_resp_ready_and_o),
    .mem_resp_header_o   (mem_resp_header_o),
    .mem_resp_data_o     (mem_resp_data_o),
    .mem_resp_v_o        (mem_resp_v_o),
    .mem_resp_last_o     (mem_resp_last_o),
    .mem_resp_ready_and_i(mem_resp_ready_and_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ordered list of message sources awaiting a response,
  // whether a multi-beat message owns the bus, and whose turn a tie is.
  int q[$];
  bit m_locked;
  bit m_lock_port;
  bit m_rr;
  int rem[2];
  int len_lo[2];
  int len_hi[2];

  task automatic step(input int pv0, input int pv1, input int prdy,
                      input int prv, input int prr, input bit rst);
    bit       g, act, ev, errdy, hd;
    bit [1:0] er, erv;
    @(negedge clk);
    reset_i = rst;
    for (int p = 0; p < 2; p++) begin
      if (rem[p] == 0) rem[p] = $urandom_range(len_lo[p], len_hi[p]);
      mem_cmd_v_i[p]          = ($urandom_range(0, 99) < ((p == 0) ? pv0 : pv1));
      mem_cmd_last_i[p]       = (rem[p] == 1);
      mem_cmd_header_i[p]     = HW'({$urandom, $urandom});
      mem_cmd_data_i[p]       = FW'({$urandom, $urandom});
      mem_resp_ready_and_i[p] = ($urandom_range(0, 99) < prr);
    end
    mem_cmd_ready_and_i = ($urandom_range(0, 99) < prdy);
    mem_resp_v_i        = ($urandom_range(0, 99) < prv);
    mem_resp_last_i     = ($urandom_range(0, 2) == 0);
    mem_resp_header_i   = HW'({$urandom, $urandom});
    mem_resp_data_i     = FW'({$urandom, $urandom});
    #1;

    if (m_locked)                 g = m_lock_port;
    else if (mem_cmd_v_i == 2'b11) g = FIXED ? 1'b1 : m_rr;
    else if (mem_cmd_v_i[1])      g = 1'b1;
    else                          g = 1'b0;
    act = !rst && (m_locked || (q.size() < OUTS));
    ev  = act && mem_cmd_v_i[g];
    er  = 2'b00;
    if (act) er[g] = mem_cmd_ready_and_i;
    check("cmd_v", {63'd0, mem_cmd_v_o}, {63'd0, ev});
    check("cmd_ready", {62'd0, mem_cmd_ready_and_o}, {62'd0, er});
    if (ev) begin
      check("cmd_header", 64'(mem_cmd_header_o), 64'(mem_cmd_header_i[g]));
      check("cmd_data", 64'(mem_cmd_data_o), 64'(mem_cmd_data_i[g]));
      check("cmd_last", {63'd0, mem_cmd_last_o}, {63'd0, mem_cmd_last_i[g]});
    end

    erv   = 2'b00;
    errdy = 1'b0;
    if (!rst && q.size() > 0) begin
      hd      = q[0][0];
      erv[hd] = mem_resp_v_i;
      errdy   = mem_resp_ready_and_i[hd];
    end
    check("resp_v", {62'd0, mem_resp_v_o}, {62'd0, erv});
    check("resp_ready", {63'd0, mem_resp_ready_and_o}, {63'd0, errdy});
    check("resp_header0", 64'(mem_resp_header_o[0]), 64'(mem_resp_header_i));
    check("resp_data1", 64'(mem_resp_data_o[1]), 64'(mem_resp_data_i));

    @(posedge clk);
    if (rst) begin
      q.delete();
      m_locked = 1'b0;
      m_rr     = 1'b0;
      rem      = '{0, 0};
    end else begin
      if (ev && mem_cmd_ready_and_i) begin
        if (!m_locked) q.push_back(int'(g));
        if (mem_cmd_last_i[g]) begin
          m_locked = 1'b0;
          m_rr     = !g;
        end else begin
          m_locked    = 1'b1;
          m_lock_port = g;
        end
        rem[g]--;
      end
      if (errdy && mem_resp_v_i && mem_resp_last_i) void'(q.pop_front());
    end
  endtask

  initial begin
    reset_i              = 1'b1;
    mem_cmd_header_i     = '0;
    mem_cmd_data_i       = '0;
    mem_cmd_v_i          = '0;
    mem_cmd_last_i       = '0;
    mem_cmd_ready_and_i  = 1'b0;
    mem_resp_header_i    = '0;
    mem_resp_data_i      = '0;
    mem_resp_v_i         = 1'b0;
    mem_resp_last_i      = 1'b0;
    mem_resp_ready_and_i = '0;
    q.delete();
    m_locked    = 1'b0;
    m_lock_port = 1'b0;
    m_rr        = 1'b0;
    rem         = '{0, 0};
    len_lo      = '{1, 1};
    len_hi      = '{1, 1};

    // Outputs held low in reset even with busy inputs
    repeat (3) step(100, 100, 100, 100, 100, 1'b1);

    // Both ports single-beat, no responses: fills the FIFO, fifth stalls
    repeat (7) step(100, 100, 100, 0, 100, 1'b0);
    // Head port refuses responses, then drain
    repeat (3) step(0, 0, 100, 100, 0, 1'b0);
    repeat (12) step(0, 0, 100, 100, 100, 1'b0);

    // Port 1 four-beat while port 0 stays valid
    step(0, 0, 0, 0, 0, 1'b1);
    len_lo = '{1, 4};
    len_hi = '{1, 4};
    repeat (12) step(100, 100, 100, 40, 100, 1'b0);

    // Randomized traffic with occasional resets
    len_lo = '{1, 1};
    len_hi = '{4, 4};
    for (int i = 0; i < 3000; i++)
      step(70, 70, 70, 60, 70, ($urandom_range(0, 299) == 0));

    // Reset in the middle of a locked four-beat message
    step(0, 0, 0, 0, 0, 1'b1);
    len_lo = '{1, 4};
    len_hi = '{1, 4};
    repeat (2) step(0, 100, 100, 0, 100, 1'b0);
    step(0, 100, 100, 0, 100, 1'b1);
    repeat (3) step(0, 0, 100, 100, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
